// File: rtl/sp_sram_be_mem.sv
// rtl/sp_sram_be_mem.sv - single-port byte-enabled synchronous SRAM with post-reset zero-fill
//
// Purpose:
//   Word-addressed single-port SRAM sitting behind the AXI-to-memory slave wrapper.
//   Reads return registered data one cycle after the request. Writes merge the bytes
//   selected by the byte enables. With INIT_ZERO=1, a sequencer clears every word
//   after reset, taking DEPTH cycles, before any request is accepted.
//
// Ports:
//   clk          rising-edge clock for all logic
//   rst          synchronous active-high reset
//   mem_req_i    access request, one per cycle, never back-pressured
//   mem_addr_i   word address
//   mem_we_i     1 = write, 0 = read
//   mem_be_i     per-byte write enables (ignored on reads)
//   mem_wdata_i  write data
//   mem_rdata_o  registered read data, held between reads
//   init_done_o  1 once the array is usable
//   err_o        one-cycle pulse: a request arrived while the fill was running

module sp_sram_be_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_req_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic                    mem_we_i,
  input  logic [DATA_WIDTH/8-1:0] mem_be_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    init_done_o,
  output logic                    err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   fill_ptr;

  // Storage array; left without reset so it maps onto block RAM.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Shared write port: the fill sequencer and user writes never overlap in time,
  // so a simple mux in front of one port is enough.
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [BE_WIDTH-1:0]     wr_be;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = mem_addr_i;
    wr_be   = mem_be_i;
    wr_data = mem_wdata_i;
    rd_en   = 1'b0;
    if (!rst) begin
      if (state == ST_FILL) begin
        wr_en   = 1'b1;
        wr_addr = fill_ptr;
        wr_be   = '1;
        wr_data = '0;
      end else if (mem_req_i) begin
        wr_en = mem_we_i;
        rd_en = !mem_we_i;
      end
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_ptr    <= '0;
      err_o       <= 1'b0;
      state       <= INIT_ZERO ? ST_FILL : ST_READY;
      init_done_o <= !INIT_ZERO;
    end else begin
      err_o <= 1'b0;
      case (state)
        ST_FILL: begin
          // Requests during the fill are dropped and flagged on the next cycle.
          err_o    <= mem_req_i;
          fill_ptr <= fill_ptr + 1'b1;
          if (fill_ptr == LAST_ADDR) begin
            state       <= ST_READY;
            init_done_o <= 1'b1;
          end
        end
        ST_READY: begin
          // Terminal until the next reset.
          state       <= ST_READY;
          init_done_o <= 1'b1;
        end
        default: begin
          state       <= ST_FILL;
          init_done_o <= 1'b0;
          fill_ptr    <= '0;
        end
      endcase
    end
  end

  // Byte-merged array write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read data register: only a read updates it, so writes and idle cycles hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata_o <= '0;
    end else if (rd_en) begin
      mem_rdata_o <= mem[mem_addr_i];
    end
  end

endmodule
